// File: rtl/bus_host_arbiter_if.sv
// Host/device bus bundle for bus_host_arbiter: N request/response host ports
// and M single-cycle ram_1p style device ports.
interface bus_host_arbiter_if #(
  parameter int NHosts    = 2,
  parameter int NDevices  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [NHosts-1:0]                     host_req_i;
  logic [NHosts-1:0]                     host_gnt_o;
  logic [NHosts-1:0]                     host_we_i;
  logic [NHosts-1:0][DataWidth/8-1:0]    host_be_i;
  logic [NHosts-1:0][AddrWidth-1:0]      host_addr_i;
  logic [NHosts-1:0][DataWidth-1:0]      host_wdata_i;
  logic [NHosts-1:0]                     host_rvalid_o;
  logic [NHosts-1:0][DataWidth-1:0]      host_rdata_o;
  logic [NHosts-1:0]                     host_err_o;

  logic [NDevices-1:0]                   dev_req_o;
  logic [NDevices-1:0]                   dev_we_o;
  logic [NDevices-1:0][DataWidth/8-1:0]  dev_be_o;
  logic [NDevices-1:0][AddrWidth-1:0]    dev_addr_o;
  logic [NDevices-1:0][DataWidth-1:0]    dev_wdata_o;
  logic [NDevices-1:0]                   dev_rvalid_i;
  logic [NDevices-1:0][DataWidth-1:0]    dev_rdata_i;
  logic [NDevices-1:0]                   dev_err_i;

  modport slave (
    input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
    input  dev_rvalid_i, dev_rdata_i, dev_err_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
  );

  modport master (
    output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
    output dev_rvalid_i, dev_rdata_i, dev_err_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
  );
endinterface

// File: rtl/bus_host_arbiter.sv
// N-host to M-device interconnect: address decode, per-device fixed/round-robin
// arbitration, 1-cycle response routing and error responses for unmapped hits.
module bus_host_arbiter #(
  parameter int NHosts    = 2,
  parameter int NDevices  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int ArbMode   = 1,
  parameter logic [NDevices-1:0][AddrWidth-1:0] DevBase = {32'h8000_0000, 32'h0000_0000},
  parameter logic [NDevices-1:0][AddrWidth-1:0] DevMask = {32'h0000_0FFF, 32'h0000_FFFF}
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  bus_host_arbiter_if.slave bus
);

  localparam int HostIdxW = (NHosts   > 1) ? $clog2(NHosts)   : 1;
  localparam int DevIdxW  = (NDevices > 1) ? $clog2(NDevices) : 1;

  logic [NHosts-1:0]                  hit_s;
  logic [NHosts-1:0][DevIdxW-1:0]     tgt_s;
  logic [NHosts-1:0]                  unm_s;
  logic [NDevices-1:0]                dev_gnt_vld_s;
  logic [NDevices-1:0][HostIdxW-1:0]  dev_gnt_host_s;
  int                                 h_idx_s;

  logic [NDevices-1:0]                pend_vld_r;
  logic [NDevices-1:0][HostIdxW-1:0]  pend_host_r;
  logic [NDevices-1:0][HostIdxW-1:0]  last_gnt_r;
  logic [NHosts-1:0]                  unm_vld_r;

  // Address decode; scanning devices downwards lets the lowest match win.
  always_comb begin
    hit_s = '0;
    tgt_s = '0;
    for (int h = 0; h < NHosts; h++) begin
      for (int d = NDevices - 1; d >= 0; d--) begin
        if ((bus.host_addr_i[h] & ~DevMask[d]) == DevBase[d]) begin
          hit_s[h] = 1'b1;
          tgt_s[h] = DevIdxW'(d);
        end else begin
          hit_s[h] = hit_s[h];
        end
      end
    end
    unm_s = bus.host_req_i & ~hit_s;
  end

  // Per-device winner selection; RR search begins just after the last winner.
  always_comb begin
    dev_gnt_vld_s  = '0;
    dev_gnt_host_s = '0;
    h_idx_s        = 0;
    for (int d = 0; d < NDevices; d++) begin
      for (int k = 0; k < NHosts; k++) begin
        if (ArbMode == 0) begin
          h_idx_s = k;
        end else begin
          h_idx_s = (int'(last_gnt_r[d]) + 1 + k) % NHosts;
        end
        if (!dev_gnt_vld_s[d] && bus.host_req_i[h_idx_s] && hit_s[h_idx_s] &&
            (tgt_s[h_idx_s] == DevIdxW'(d))) begin
          dev_gnt_vld_s[d]  = 1'b1;
          dev_gnt_host_s[d] = HostIdxW'(h_idx_s);
        end else begin
          dev_gnt_vld_s[d]  = dev_gnt_vld_s[d];
        end
      end
    end
  end

  // Grants and device-side forwarding; idle device ports are held at zero.
  always_comb begin
    bus.host_gnt_o  = unm_s;
    bus.dev_req_o   = '0;
    bus.dev_we_o    = '0;
    bus.dev_be_o    = '0;
    bus.dev_addr_o  = '0;
    bus.dev_wdata_o = '0;
    for (int d = 0; d < NDevices; d++) begin
      if (dev_gnt_vld_s[d]) begin
        bus.host_gnt_o[dev_gnt_host_s[d]] = 1'b1;
        bus.dev_req_o[d]   = 1'b1;
        bus.dev_we_o[d]    = bus.host_we_i[dev_gnt_host_s[d]];
        bus.dev_be_o[d]    = bus.host_be_i[dev_gnt_host_s[d]];
        bus.dev_addr_o[d]  = bus.host_addr_i[dev_gnt_host_s[d]];
        bus.dev_wdata_o[d] = bus.host_wdata_i[dev_gnt_host_s[d]];
      end else begin
        bus.dev_req_o[d]   = 1'b0;
      end
    end
  end

  // Response routing; a device that fails to answer is turned into an error.
  always_comb begin
    bus.host_rvalid_o = unm_vld_r;
    bus.host_err_o    = unm_vld_r;
    bus.host_rdata_o  = '0;
    for (int d = 0; d < NDevices; d++) begin
      if (pend_vld_r[d]) begin
        bus.host_rvalid_o[pend_host_r[d]] = 1'b1;
        bus.host_rdata_o[pend_host_r[d]]  = bus.dev_rdata_i[d];
        bus.host_err_o[pend_host_r[d]]    = bus.dev_err_i[d] | ~bus.dev_rvalid_i[d];
      end else begin
        bus.host_rvalid_o = bus.host_rvalid_o;
      end
    end
  end

  // Pending-response tracking and round-robin pointers.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      pend_vld_r  <= '0;
      pend_host_r <= '0;
      unm_vld_r   <= '0;
      for (int d = 0; d < NDevices; d++) begin
        last_gnt_r[d] <= HostIdxW'(NHosts - 1);
      end
    end else begin
      pend_vld_r  <= dev_gnt_vld_s;
      pend_host_r <= dev_gnt_host_s;
      unm_vld_r   <= unm_s;
      for (int d = 0; d < NDevices; d++) begin
        if (dev_gnt_vld_s[d]) begin
          last_gnt_r[d] <= dev_gnt_host_s[d];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Runs a fixed-priority and a round-robin arbiter side by side on shared stimulus
// and compares both against a per-cycle behavioural model.
module tb_bus_host_arbiter;

  localparam int NH = 2;
  localparam int ND = 2;

  logic clk_sys;
  logic rst_sys_n;

  bus_host_arbiter_if #(.NHosts(NH), .NDevices(ND), .AddrWidth(32), .DataWidth(32)) bus_fx ();
  bus_host_arbiter_if #(.NHosts(NH), .NDevices(ND), .AddrWidth(32), .DataWidth(32)) bus_rr ();

  bus_host_arbiter #(.NHosts(NH), .NDevices(ND), .AddrWidth(32), .DataWidth(32), .ArbMode(0))
    u_dut_fx (.clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bus_fx));
  bus_host_arbiter #(.NHosts(NH), .NDevices(ND), .AddrWidth(32), .DataWidth(32), .ArbMode(1))
    u_dut_rr (.clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bus_rr));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus shared by both DUTs
  logic [1:0]        s_req, s_we, s_drv, s_derr;
  logic [1:0][3:0]   s_be;
  logic [1:0][31:0]  s_addr, s_wdata, s_drdata;

  // model state: [mode][device] pointers, [mode][host] pending responses
  int m_last [2][2];
  bit m_rv   [2][2];
  int m_rdev [2][2];
  int e_win  [2][2];

  logic [31:0] dev_base [2] = '{32'h0000_0000, 32'h8000_0000};
  logic [31:0] dev_mask [2] = '{32'h0000_FFFF, 32'h0000_0FFF};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int d = 0; d < ND; d++) begin
      if ((a & ~dev_mask[d]) == dev_base[d]) return d;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2; i++) begin
        m_last[m][i] = NH - 1;
        m_rv[m][i]   = 1'b0;
        m_rdev[m][i] = -1;
      end
    end
  endtask

  // winner = requester with the smallest rank; rank is the index (fixed) or
  // the distance after the previous winner (round-robin)
  task automatic model_eval(input int m);
    for (int d = 0; d < ND; d++) begin
      int best = -1;
      int best_k = NH;
      for (int h = 0; h < NH; h++) begin
        if (s_req[h] && decode(s_addr[h]) == d) begin
          int k = (m == 0) ? h : (h - m_last[m][d] - 1 + 2 * NH) % NH;
          if (k < best_k) begin
            best_k = k;
            best = h;
          end
        end
      end
      e_win[m][d] = best;
    end
  endtask

  task automatic model_advance(input int m);
    for (int h = 0; h < NH; h++) begin
      m_rv[m][h] = s_req[h] && (decode(s_addr[h]) < 0);
      m_rdev[m][h] = -1;
    end
    for (int d = 0; d < ND; d++) begin
      if (e_win[m][d] >= 0) begin
        m_rv[m][e_win[m][d]]   = 1'b1;
        m_rdev[m][e_win[m][d]] = d;
        m_last[m][d]           = e_win[m][d];
      end
    end
  endtask

  task automatic check_mode(input int m);
    logic [1:0] a_g, a_rv, a_err, a_dreq, a_dwe, x_g, x_rv, x_err, x_dreq, x_dwe;
    logic [1:0][3:0]  a_be, x_be;
    logic [1:0][31:0] a_rd, a_addr, a_wd, x_rd, x_addr, x_wd;
    string sfx = (m == 0) ? "_fx" : "_rr";
    if (m == 0) begin
      a_g = bus_fx.host_gnt_o;   a_rv = bus_fx.host_rvalid_o; a_err = bus_fx.host_err_o;
      a_rd = bus_fx.host_rdata_o; a_dreq = bus_fx.dev_req_o;  a_dwe = bus_fx.dev_we_o;
      a_be = bus_fx.dev_be_o;    a_addr = bus_fx.dev_addr_o;  a_wd = bus_fx.dev_wdata_o;
    end else begin
      a_g = bus_rr.host_gnt_o;   a_rv = bus_rr.host_rvalid_o; a_err = bus_rr.host_err_o;
      a_rd = bus_rr.host_rdata_o; a_dreq = bus_rr.dev_req_o;  a_dwe = bus_rr.dev_we_o;
      a_be = bus_rr.dev_be_o;    a_addr = bus_rr.dev_addr_o;  a_wd = bus_rr.dev_wdata_o;
    end
    x_g = '0; x_rv = '0; x_err = '0; x_dreq = '0; x_dwe = '0;
    x_be = '0; x_rd = '0; x_addr = '0; x_wd = '0;
    for (int h = 0; h < NH; h++) begin
      if (s_req[h] && decode(s_addr[h]) < 0) x_g[h] = 1'b1;
      if (m_rv[m][h]) begin
        x_rv[h] = 1'b1;
        if (m_rdev[m][h] < 0) begin
          x_err[h] = 1'b1;
        end else begin
          x_rd[h]  = s_drdata[m_rdev[m][h]];
          x_err[h] = s_derr[m_rdev[m][h]] | ~s_drv[m_rdev[m][h]];
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      int w = e_win[m][d];
      if (w >= 0) begin
        x_g[w] = 1'b1;  x_dreq[d] = 1'b1;  x_dwe[d] = s_we[w];
        x_be[d] = s_be[w];  x_addr[d] = s_addr[w];  x_wd[d] = s_wdata[w];
      end
    end
    check_eq({"gnt", sfx},       64'(a_g),    64'(x_g));
    check_eq({"rvalid", sfx},    64'(a_rv),   64'(x_rv));
    check_eq({"err", sfx},       64'(a_err),  64'(x_err));
    check_eq({"rdata", sfx},     64'(a_rd),   64'(x_rd));
    check_eq({"dev_req", sfx},   64'(a_dreq), 64'(x_dreq));
    check_eq({"dev_we", sfx},    64'(a_dwe),  64'(x_dwe));
    check_eq({"dev_be", sfx},    64'(a_be),   64'(x_be));
    check_eq({"dev_addr", sfx},  64'(a_addr), 64'(x_addr));
    check_eq({"dev_wdata", sfx}, 64'(a_wd),   64'(x_wd));
  endtask

  task automatic drive();
    bus_fx.host_req_i = s_req;   bus_rr.host_req_i = s_req;
    bus_fx.host_we_i = s_we;     bus_rr.host_we_i = s_we;
    bus_fx.host_be_i = s_be;     bus_rr.host_be_i = s_be;
    bus_fx.host_addr_i = s_addr; bus_rr.host_addr_i = s_addr;
    bus_fx.host_wdata_i = s_wdata; bus_rr.host_wdata_i = s_wdata;
    bus_fx.dev_rvalid_i = s_drv; bus_rr.dev_rvalid_i = s_drv;
    bus_fx.dev_rdata_i = s_drdata; bus_rr.dev_rdata_i = s_drdata;
    bus_fx.dev_err_i = s_derr;   bus_rr.dev_err_i = s_derr;
  endtask

  // one clock: drive at negedge, check combinational view, then model the posedge
  task automatic step(input logic rst_v);
    @(negedge clk_sys);
    rst_sys_n = rst_v;
    if (!rst_v) begin
      s_req = 2'b00;
      model_reset();
    end
    drive();
    #2;
    for (int m = 0; m < 2; m++) begin
      model_eval(m);
      check_mode(m);
      if (rst_v) model_advance(m);
    end
  endtask

  task automatic set_idle();
    s_req = 2'b00; s_we = 2'b00; s_be = '0; s_addr = '0; s_wdata = '0;
    s_drv = 2'b11; s_derr = 2'b00;
    s_drdata[0] = $urandom; s_drdata[1] = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 32'($urandom) & 32'h0000_FFFF;
      2, 3:    return 32'h8000_0000 | (32'($urandom) & 32'h0000_0FFF);
      4:       return 32'h4000_0000 | (32'($urandom) & 32'h0000_FFFF);
      default: return ($urandom_range(0, 1) == 0) ? 32'h0001_0000 : 32'h8000_1000;
    endcase
  endfunction

  initial begin
    rst_sys_n = 1'b0;
    set_idle();
    model_reset();
    drive();
    step(1'b0);
    step(1'b0);

    // RR alternation from reset; fixed mode always picks host 0
    s_req = 2'b11; s_addr[0] = 32'h0000_0010; s_addr[1] = 32'h0000_0020;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check_eq("rr_alternate", 64'(bus_rr.host_gnt_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      check_eq("fx_lowest", 64'(bus_fx.host_gnt_o), 64'h1);
    end
    set_idle();
    step(1'b1);

    // fixed priority on a shared address, then the loser gets through
    s_req = 2'b11; s_addr[0] = 32'h0000_0010; s_addr[1] = 32'h0000_0010;
    step(1'b1);
    check_eq("fx_first_gnt", 64'(bus_fx.host_gnt_o), 64'h1);
    check_eq("fx_dev0_addr", 64'(bus_fx.dev_addr_o[0]), 64'h10);
    s_req = 2'b10; s_drdata[0] = 32'h1234_5678;
    step(1'b1);
    check_eq("fx_h0_rvalid", 64'(bus_fx.host_rvalid_o[0]), 64'h1);
    check_eq("fx_h0_rdata", 64'(bus_fx.host_rdata_o[0]), 64'h1234_5678);
    check_eq("fx_h1_gnt", 64'(bus_fx.host_gnt_o), 64'h2);
    set_idle();
    step(1'b1);

    // parallel read on dev0 and write on dev1
    s_req = 2'b11; s_we = 2'b10; s_addr[0] = 32'h0000_0100; s_addr[1] = 32'h8000_0004;
    s_be[1] = 4'b0011; s_wdata[1] = 32'hDEAD_BEEF;
    step(1'b1);
    check_eq("par_gnt", 64'(bus_rr.host_gnt_o), 64'h3);
    check_eq("par_wdata", 64'(bus_rr.dev_wdata_o[1]), 64'hDEAD_BEEF);
    check_eq("par_be", 64'(bus_rr.dev_be_o[1]), 64'h3);
    set_idle();
    step(1'b1);
    check_eq("par_rvalid", 64'(bus_rr.host_rvalid_o), 64'h3);

    // unmapped access
    s_req = 2'b10; s_addr[1] = 32'h4000_0000;
    step(1'b1);
    check_eq("unm_gnt", 64'(bus_rr.host_gnt_o), 64'h2);
    check_eq("unm_no_dev", 64'(bus_rr.dev_req_o), 64'h0);
    set_idle();
    step(1'b1);
    check_eq("unm_resp", {62'h0, bus_rr.host_rvalid_o[1], bus_rr.host_err_o[1]}, 64'h3);
    check_eq("unm_rdata", 64'(bus_rr.host_rdata_o[1]), 64'h0);

    // device silent after a grant
    s_req = 2'b01; s_addr[0] = 32'h0000_0040;
    step(1'b1);
    set_idle();
    s_drv = 2'b00;
    step(1'b1);
    check_eq("miss_err", {62'h0, bus_fx.host_rvalid_o[0], bus_fx.host_err_o[0]}, 64'h3);
    set_idle();
    step(1'b1);

    // reset hits while a response is pending
    s_req = 2'b11; s_addr[0] = 32'h0000_0010; s_addr[1] = 32'h0000_0020;
    step(1'b1);
    step(1'b0);
    check_eq("rst_rvalid", 64'(bus_rr.host_rvalid_o), 64'h0);
    s_req = 2'b11;
    step(1'b1);
    check_eq("rst_rr_first", 64'(bus_rr.host_gnt_o), 64'h1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int h = 0; h < NH; h++) begin
        s_req[h] = ($urandom_range(0, 3) != 0);
        s_we[h] = ($urandom_range(0, 1) != 0);
        s_be[h] = 4'($urandom);
        s_addr[h] = rand_addr();
        s_wdata[h] = $urandom;
      end
      for (int d = 0; d < ND; d++) begin
        s_drv[d] = ($urandom_range(0, 7) != 0);
        s_derr[d] = ($urandom_range(0, 7) == 0);
        s_drdata[d] = $urandom;
      end
      step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

Parametrised N-host to M-device memory interconnect for Ibex-based FPGA tops. It replaces the fixed two-port instruction/data SRAM mux with per-device arbitration, so hosts targeting different devices proceed in the same cycle. It adds selectable fixed-priority or round-robin arbitration, address decoding against a configurable map, and error responses for unmapped accesses. It sits between `ibex_top` (instr and data ports as separate hosts, plus any DMA) and SRAM/peripheral blocks that follow the single-cycle `ram_1p` protocol.

## Interface
- `NHosts`, 2, number of host ports (1..8).
- `NDevices`, 2, number of device ports (1..8).
- `AddrWidth`, 32, address width.
- `DataWidth`, 32, data width; byte enables are `DataWidth/8`.
- `ArbMode`, 1, 0 = fixed priority (lowest host index wins), 1 = round-robin per device.
- `DevBase`, {32'h8000_0000, 32'h0000_0000}, packed array `[NDevices][AddrWidth]`, base address per device.
- `DevMask`, {32'h0000_0FFF, 32'h0000_FFFF}, packed array, per-device offset mask.

Ports:
- `clk_sys`  in  1  system clock.
- `rst_sys_n`  in  1  reset, asynchronous, active-low.
- `host_req_i`  in  NHosts  request.
- `host_gnt_o`  out  NHosts  grant, same cycle as accepted req.
- `host_we_i`  in  NHosts  write enable.
- `host_be_i`  in  NHosts×DataWidth/8  byte enables.
- `host_addr_i`  in  NHosts×AddrWidth  address.
- `host_wdata_i`  in  NHosts×DataWidth  write data.
- `host_rvalid_o`  out  NHosts  response valid.
- `host_rdata_o`  out  NHosts×DataWidth  read data.
- `host_err_o`  out  NHosts  error, qualified by rvalid.
- `dev_req_o`  out  NDevices  device request.
- `dev_we_o`, `dev_be_o`, `dev_addr_o`, `dev_wdata_o`  out  per device  forwarded from the granted host, full unmodified address.
- `dev_rvalid_i`  in  NDevices  device response valid.
- `dev_rdata_i`  in  NDevices×DataWidth  device read data.
- `dev_err_i`  in  NDevices  device error.

## Operation
- Decode: host h targets device d when `(addr & ~DevMask[d]) == DevBase[d]`. With multiple matches, the lowest d wins. With no match, the request is unmapped.
- Per-device arbitration: each device independently selects one requesting host whose address decodes to it.
  - Fixed mode: lowest index wins.
  - RR mode: the search starts at `last_gnt[d]+1` (mod NHosts). `last_gnt[d]` updates only on a grant to d.
- Granted host: `host_gnt_o[h]=1` and `dev_req_o[d]=1` with h's `we/be/addr/wdata`. Non-requested device outputs are driven to 0.
- Unmapped request: granted immediately, with no device access. The next cycle returns `rvalid=1`, `err=1`, `rdata=0`. It never competes with mapped requests.
- Response routing: registered per-device `pend_vld[d]` and `pend_host[d]` capture each grant.
  - The cycle after a grant, host `pend_host[d]` gets `rvalid=1`, `rdata=dev_rdata_i[d]`, `err=dev_err_i[d] | ~dev_rvalid_i[d]` (a missing device response is reported as an error, never a hang).
- A host has at most one request per cycle, so it receives at most one response per cycle. Back-to-back grants to the same host are allowed (pipelined, one response per cycle).
- When no response is due, `host_rdata_o` and `host_err_o` are 0.

## Timing
- Reset values: all `host_gnt_o`, `host_rvalid_o`, `host_err_o`, `host_rdata_o`, and all `dev_*_o` are 0. `pend_vld`=0. `last_gnt[d]=NHosts-1`, so host 0 has first RR priority.
- Grant and device request are combinational from `host_req_i`/`host_addr_i` (same cycle). Response latency is exactly 1 cycle after the grant for both mapped and unmapped requests.
- Devices must accept every request (no device-side stall) and respond exactly 1 cycle later.
- Ungranted hosts hold req/attributes stable until granted (Ibex rule). The arbiter has no requirement on losers beyond that.
- Simultaneous events: a grant to host h and a response to h from an earlier grant may coincide. Both are honoured (the gnt and rvalid are independent).
- Reset asserted mid-transaction: pending responses are discarded, no rvalid is issued after reset, and RR pointers return to the reset value.
- Deassertion of reset is synchronised externally (clkgen). The block has no reset synchroniser.

## Test plan
- Fixed mode, hosts 0 and 1 both read 0x0000_0010 in the same cycle. Required: gnt=01, dev0 addr=0x10. Next cycle host0 rvalid with dev0 rdata. The following cycle host1 is granted.
- RR mode, both hosts continuously request dev0 for 6 cycles. Required grants alternate 0,1,0,1,0,1, starting with host 0 after reset.
- Parallel access: host0 reads 0x100 (dev0) while host1 writes 0x8000_0004, be=4'b0011, wdata=0xDEAD_BEEF (dev1), in the same cycle. Required: both granted, dev1 sees the exact write, and both hosts get rvalid next cycle.
- Unmapped: host1 reads 0x4000_0000. Required: gnt same cycle. Next cycle `rvalid=1`, `err=1`, `rdata=0`, and no `dev_req_o` is asserted.
- Missing response: dev0 holds `dev_rvalid_i=0` after a grant to host0. Required: host0 gets rvalid with err=1 one cycle later.
- Reset asserted the cycle after a grant. Required: no rvalid is issued, all outputs are 0, and the first post-reset RR grant goes to host 0.
